// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction fetch front end.
//   XLEN       : architectural data/address width
//   NOP_INSTR  : addi x0,x0,0, presented to decode whenever no instruction is valid
//   fetch_state_e : fetch FSM state encoding
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,  // first cycle out of reset
        FS_REQ  = 2'd1,  // presenting a request to instruction memory
        FS_WAIT = 2'd2,  // one live request outstanding
        FS_DROP = 2'd3   // one stale request outstanding, its data will be thrown away
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Two-entry FIFO with synchronous flush that holds {pc, instruction} pairs
// between instruction memory and decode.
// Ports:
//   i_clk        clock
//   i_reset_n    synchronous reset, active-low
//   i_flush      empties the queue (wins over push and pop)
//   i_push       write i_push_data at the tail
//   i_push_data  entry to write
//   i_pop        drop the head entry (ignored when empty)
//   o_head_data  head entry, meaningful only when o_count != 0
//   o_count      number of valid entries, 0..2
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] storage [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = i_pop && (count != 2'd0);
    // A full queue may still accept a write when the head leaves in the same cycle.
    assign do_push = i_push && ((count != 2'd2) || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // NOTE: the storage array is deliberately not reset; count qualifies every
    // read, so clearing it would only add reset fan-out.
    always_ff @(posedge i_clk) begin
        if (do_push) storage[wr_ptr] <= i_push_data;
    end

    assign o_head_data = storage[rd_ptr];
    assign o_count     = count;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction fetch front end. Owns the PC, issues one word request at a time
// to instruction memory, buffers returned words in a 2-entry queue and presents
// them to decode with a valid/ready handshake. EX redirects flush the queue and
// restart fetch at the new target.
// Ports:
//   i_clk, i_reset_n        clock, synchronous active-low reset
//   o_imem_req/o_imem_addr  fetch request and word-aligned address
//   i_imem_ready            memory accepts the request this cycle
//   i_imem_rsp_valid/_data  in-order read response
//   i_redirect_valid/_pc    taken branch/jump target from EX
//   i_id_ready              decode can accept (0 = stall)
//   o_valid/o_pc_out/o_instruction_out  instruction presented to decode
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ready,
    input  logic            i_imem_rsp_valid,
    input  logic [XLEN-1:0] i_imem_rsp_data,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_id_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc_out,
    output logic [XLEN-1:0] o_instruction_out
);

    import riscv_pkg::*;

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_next;
    logic [XLEN-1:0]   req_addr;      // address of the request currently outstanding
    logic              outstanding;
    logic              handshake;
    logic              q_push;
    logic [1:0]        q_count;
    logic [2*XLEN-1:0] q_head;
    logic [XLEN-1:0]   redirect_target;
    logic              redirect_lsbs_unused;

    assign redirect_target      = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_lsbs_unused = ^i_redirect_pc[1:0];

    assign outstanding = (state == FS_WAIT) || (state == FS_DROP);
    // Only request when the word is guaranteed a free queue slot on return.
    assign o_imem_req  = (state == FS_REQ) && ((3'(q_count) + 3'(outstanding)) < 3'd2);
    assign o_imem_addr = pc;
    assign handshake   = o_imem_req && i_imem_ready;

    // NOTE: every signal assigned here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        q_push     = 1'b0;

        case (state)
            FS_IDLE: state_next = FS_REQ;
            FS_REQ: begin
                if (handshake) begin
                    pc_next    = pc + XLEN'(4);
                    state_next = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (i_imem_rsp_valid) begin
                    q_push     = 1'b1;
                    state_next = FS_REQ;
                end
            end
            FS_DROP: begin
                if (i_imem_rsp_valid) state_next = FS_REQ;
            end
            default: state_next = FS_IDLE;
        endcase

        if (i_redirect_valid) begin
            pc_next = redirect_target;
            q_push  = 1'b0;
            // A request that memory has taken still owes one response. If that
            // response lands in this very cycle it is consumed (and discarded)
            // now; otherwise it must be absorbed later in DROP.
            case (state)
                FS_REQ:           state_next = handshake ? FS_DROP : FS_REQ;
                FS_WAIT, FS_DROP: state_next = i_imem_rsp_valid ? FS_REQ : FS_DROP;
                default:          state_next = FS_REQ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state    <= FS_IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (handshake) req_addr <= pc;
        end
    end

    fetch_queue #(
        .WIDTH (2 * XLEN)
    ) u_queue (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_flush     (i_redirect_valid),
        .i_push      (q_push),
        .i_push_data ({req_addr, i_imem_rsp_data}),
        .i_pop       (o_valid && i_id_ready),
        .o_head_data (q_head),
        .o_count     (q_count)
    );

    // Outputs come straight from queue registers; the mux only substitutes
    // the idle values when the queue is empty.
    assign o_valid           = (q_count != 2'd0);
    assign o_pc_out          = o_valid ? q_head[2*XLEN-1:XLEN] : '0;
    assign o_instruction_out = o_valid ? q_head[XLEN-1:0] : XLEN'(NOP_INSTR);

endmodule
